// File: rtl/axi4lite_cpuif_pkg.sv
// Shared types and helpers for the AXI4-Lite to cpuif bridge.
//   axi_resp_e      : AXI response codes driven on BRESP/RRESP
//   bridge_state_e  : bridge request/response sequencer states
//   strb_to_bitstrb : expands byte strobes into a per-bit write enable
package axi4lite_cpuif_pkg;

    localparam int unsigned MAX_DATA_WIDTH = 64;
    localparam int unsigned MAX_STRB_WIDTH = MAX_DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } axi_resp_e;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        WAIT_ACK = 2'b01,
        RESP     = 2'b10
    } bridge_state_e;

    // Each strobe bit enables its whole byte lane; callers truncate to their width.
    function automatic logic [MAX_DATA_WIDTH-1:0] strb_to_bitstrb(
        input logic [MAX_STRB_WIDTH-1:0] strb
    );
        logic [MAX_DATA_WIDTH-1:0] bits;
        bits = '0;
        for (int i = 0; i < int'(MAX_STRB_WIDTH); i++) begin
            bits[8*i +: 8] = {8{strb[i]}};
        end
        return bits;
    endfunction

endpackage

// File: rtl/axi4lite_cpuif_bridge_hold_reg.sv
// One-entry valid/ready holding register for an AXI4-Lite request channel.
//   clk, rst  : clock, asynchronous active-high reset
//   in_valid  : channel VALID from the master
//   in_ready  : channel READY (registered; high whenever the entry is free)
//   in_data   : channel payload
//   free      : consumer takes the available entry this cycle
//   avail_c   : an entry is available (held, or arriving this cycle)
//   data_c    : payload of the available entry
module axi4lite_hold_reg #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             free,
    output logic             avail_c,
    output logic [WIDTH-1:0] data_c
);

    logic             held_q, held_d;
    logic             ready_q, ready_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             accept_c;

    assign accept_c = in_valid && ready_q;
    // An arriving beat bypasses the register so it can be granted in its own cycle.
    assign avail_c  = held_q || accept_c;
    assign data_c   = held_q ? data_q : in_data;
    assign in_ready = ready_q;

    // Entry occupancy and payload capture.
    always_comb begin
        held_d = held_q;
        data_d = data_q;
        if (free) begin
            held_d = 1'b0;
        end else if (accept_c) begin
            held_d = 1'b1;
        end
        if (accept_c) begin
            data_d = in_data;
        end
        ready_d = !held_d;
    end

    // READY stays low through reset and rises on the first clock afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            held_q  <= 1'b0;
            ready_q <= 1'b0;
            data_q  <= '0;
        end else begin
            held_q  <= held_d;
            ready_q <= ready_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/axi4lite_cpuif_bridge.sv
// AXI4-Lite slave front-end driving the register block's single-request cpuif bus.
// One cpuif transaction is outstanding at a time; AW, W and AR each have a
// one-entry holding register, and B/R responses are held until accepted.
// Optional: define AXI4LITE_CPUIF_BRIDGE_TIMEOUT_EN to force an SLVERR response
// when no matching ack arrives within TIMEOUT_CYCLES.
//   clk, rst            : clock, asynchronous active-high reset
//   s_axil_aw*/w*/b*    : AXI4-Lite write address, data and response channels
//   s_axil_ar*/r*       : AXI4-Lite read address and data channels
//   cpuif_req*          : one-cycle request with registered address/data/bit strobe
//   cpuif_rd_*/wr_*     : read/write completion, error and read data
module axi4lite_cpuif_bridge
    import axi4lite_cpuif_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s_axil_awvalid,
    output logic                    s_axil_awready,
    input  logic [ADDR_WIDTH-1:0]   s_axil_awaddr,
    input  logic                    s_axil_wvalid,
    output logic                    s_axil_wready,
    input  logic [DATA_WIDTH-1:0]   s_axil_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_axil_wstrb,
    output logic                    s_axil_bvalid,
    input  logic                    s_axil_bready,
    output logic [1:0]              s_axil_bresp,
    input  logic                    s_axil_arvalid,
    output logic                    s_axil_arready,
    input  logic [ADDR_WIDTH-1:0]   s_axil_araddr,
    output logic                    s_axil_rvalid,
    input  logic                    s_axil_rready,
    output logic [DATA_WIDTH-1:0]   s_axil_rdata,
    output logic [1:0]              s_axil_rresp,
    output logic                    cpuif_req,
    output logic                    cpuif_req_is_wr,
    output logic [ADDR_WIDTH-1:0]   cpuif_addr,
    output logic [DATA_WIDTH-1:0]   cpuif_wr_data,
    output logic [DATA_WIDTH-1:0]   cpuif_wr_bitstrb,
    input  logic                    cpuif_rd_ack,
    input  logic                    cpuif_rd_err,
    input  logic [DATA_WIDTH-1:0]   cpuif_rd_data,
    input  logic                    cpuif_wr_ack,
    input  logic                    cpuif_wr_err
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned W_WIDTH    = DATA_WIDTH + STRB_WIDTH;
    // Clears the byte-offset bits so cpuif sees word-aligned addresses.
    localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ~ADDR_WIDTH'(STRB_WIDTH - 1);

    // Holding register interfaces.
    logic                  aw_avail_c, w_avail_c, ar_avail_c;
    logic                  aw_free_c, w_free_c, ar_free_c;
    logic [ADDR_WIDTH-1:0] aw_addr_c, ar_addr_c;
    logic [W_WIDTH-1:0]    w_data_c;

    axi4lite_hold_reg #(.WIDTH(ADDR_WIDTH)) u_aw_hold (
        .clk      (clk),
        .rst      (rst),
        .in_valid (s_axil_awvalid),
        .in_ready (s_axil_awready),
        .in_data  (s_axil_awaddr),
        .free     (aw_free_c),
        .avail_c  (aw_avail_c),
        .data_c   (aw_addr_c)
    );

    axi4lite_hold_reg #(.WIDTH(W_WIDTH)) u_w_hold (
        .clk      (clk),
        .rst      (rst),
        .in_valid (s_axil_wvalid),
        .in_ready (s_axil_wready),
        .in_data  ({s_axil_wstrb, s_axil_wdata}),
        .free     (w_free_c),
        .avail_c  (w_avail_c),
        .data_c   (w_data_c)
    );

    axi4lite_hold_reg #(.WIDTH(ADDR_WIDTH)) u_ar_hold (
        .clk      (clk),
        .rst      (rst),
        .in_valid (s_axil_arvalid),
        .in_ready (s_axil_arready),
        .in_data  (s_axil_araddr),
        .free     (ar_free_c),
        .avail_c  (ar_avail_c),
        .data_c   (ar_addr_c)
    );

    // Sequencer state and registered outputs.
    bridge_state_e         state_q, state_d;
    logic                  last_wr_q, last_wr_d;
    logic                  req_q, req_d;
    logic                  is_wr_q, is_wr_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic [DATA_WIDTH-1:0] bitstrb_q, bitstrb_d;
    logic                  bvalid_q, bvalid_d;
    axi_resp_e             bresp_q, bresp_d;
    logic                  rvalid_q, rvalid_d;
    axi_resp_e             rresp_q, rresp_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic wr_elig_c, rd_elig_c, grant_wr_c, grant_rd_c;
    logic ack_c, err_c, resp_hs_c;

`ifdef AXI4LITE_CPUIF_BRIDGE_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    // Next-state, grant arbitration and response capture.
    always_comb begin
        state_d    = state_q;
        last_wr_d  = last_wr_q;
        req_d      = 1'b0;
        is_wr_d    = is_wr_q;
        addr_d     = addr_q;
        wr_data_d  = wr_data_q;
        bitstrb_d  = bitstrb_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        rvalid_d   = rvalid_q;
        rresp_d    = rresp_q;
        rdata_d    = rdata_q;
        aw_free_c  = 1'b0;
        w_free_c   = 1'b0;
        ar_free_c  = 1'b0;
        wr_elig_c  = aw_avail_c && w_avail_c;
        rd_elig_c  = ar_avail_c;
        grant_wr_c = 1'b0;
        grant_rd_c = 1'b0;
        ack_c      = is_wr_q ? cpuif_wr_ack : cpuif_rd_ack;
        err_c      = is_wr_q ? cpuif_wr_err : cpuif_rd_err;
        resp_hs_c  = is_wr_q ? s_axil_bready : s_axil_rready;
`ifdef AXI4LITE_CPUIF_BRIDGE_TIMEOUT_EN
        cnt_d      = cnt_q;
`endif

        case (state_q)
            IDLE: begin
                // Write wins a tie unless the previous grant was also a write.
                grant_wr_c = wr_elig_c && !(rd_elig_c && last_wr_q);
                grant_rd_c = rd_elig_c && !grant_wr_c;
                if (grant_wr_c) begin
                    req_d     = 1'b1;
                    is_wr_d   = 1'b1;
                    addr_d    = aw_addr_c & ADDR_MASK;
                    wr_data_d = w_data_c[DATA_WIDTH-1:0];
                    bitstrb_d = DATA_WIDTH'(strb_to_bitstrb(
                                    MAX_STRB_WIDTH'(w_data_c[W_WIDTH-1:DATA_WIDTH])));
                    last_wr_d = 1'b1;
                    aw_free_c = 1'b1;
                    w_free_c  = 1'b1;
                    state_d   = WAIT_ACK;
                end else if (grant_rd_c) begin
                    req_d     = 1'b1;
                    is_wr_d   = 1'b0;
                    addr_d    = ar_addr_c & ADDR_MASK;
                    wr_data_d = '0;
                    bitstrb_d = '0;
                    last_wr_d = 1'b0;
                    ar_free_c = 1'b1;
                    state_d   = WAIT_ACK;
                end
`ifdef AXI4LITE_CPUIF_BRIDGE_TIMEOUT_EN
                cnt_d = '0;
`endif
            end

            WAIT_ACK: begin
                // The ack may land in the request cycle itself.
                if (ack_c) begin
                    state_d = RESP;
                    if (is_wr_q) begin
                        bvalid_d = 1'b1;
                        bresp_d  = err_c ? SLVERR : OKAY;
                    end else begin
                        rvalid_d = 1'b1;
                        rresp_d  = err_c ? SLVERR : OKAY;
                        rdata_d  = cpuif_rd_data;
                    end
                end
`ifdef AXI4LITE_CPUIF_BRIDGE_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    // No ack in time: answer with an error; a late ack finds us past WAIT_ACK.
                    state_d = RESP;
                    if (is_wr_q) begin
                        bvalid_d = 1'b1;
                        bresp_d  = SLVERR;
                    end else begin
                        rvalid_d = 1'b1;
                        rresp_d  = SLVERR;
                        rdata_d  = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end

            RESP: begin
                if (resp_hs_c) begin
                    bvalid_d = 1'b0;
                    rvalid_d = 1'b0;
                    state_d  = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; an in-flight transaction is dropped on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            last_wr_q <= 1'b0;
            req_q     <= 1'b0;
            is_wr_q   <= 1'b0;
            addr_q    <= '0;
            wr_data_q <= '0;
            bitstrb_q <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= OKAY;
            rvalid_q  <= 1'b0;
            rresp_q   <= OKAY;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            last_wr_q <= last_wr_d;
            req_q     <= req_d;
            is_wr_q   <= is_wr_d;
            addr_q    <= addr_d;
            wr_data_q <= wr_data_d;
            bitstrb_q <= bitstrb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rvalid_q  <= rvalid_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
        end
    end

`ifdef AXI4LITE_CPUIF_BRIDGE_TIMEOUT_EN
    // Cycles spent waiting for the current ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    assign cpuif_req        = req_q;
    assign cpuif_req_is_wr  = is_wr_q;
    assign cpuif_addr       = addr_q;
    assign cpuif_wr_data    = wr_data_q;
    assign cpuif_wr_bitstrb = bitstrb_q;
    assign s_axil_bvalid    = bvalid_q;
    assign s_axil_bresp     = bresp_q;
    assign s_axil_rvalid    = rvalid_q;
    assign s_axil_rresp     = rresp_q;
    assign s_axil_rdata     = rdata_q;

endmodule

// File: tb/tb_axi4lite_cpuif_bridge.sv
// Scoreboard bench for axi4lite_cpuif_bridge: stimulus pushes expected cpuif
// requests and AXI responses; a monitor pops and compares as the DUT presents them.
module tb_axi4lite_cpuif_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_axil_awvalid = 1'b0, s_axil_awready;
    logic [31:0] s_axil_awaddr = '0;
    logic        s_axil_wvalid = 1'b0, s_axil_wready;
    logic [31:0] s_axil_wdata = '0;
    logic [3:0]  s_axil_wstrb = '0;
    logic        s_axil_bvalid, s_axil_bready = 1'b1;
    logic [1:0]  s_axil_bresp;
    logic        s_axil_arvalid = 1'b0, s_axil_arready;
    logic [31:0] s_axil_araddr = '0;
    logic        s_axil_rvalid, s_axil_rready = 1'b1;
    logic [31:0] s_axil_rdata;
    logic [1:0]  s_axil_rresp;
    logic        cpuif_req, cpuif_req_is_wr;
    logic [31:0] cpuif_addr, cpuif_wr_data, cpuif_wr_bitstrb;
    logic        cpuif_rd_ack = 1'b0, cpuif_rd_err = 1'b0;
    logic [31:0] cpuif_rd_data = '0;
    logic        cpuif_wr_ack = 1'b0, cpuif_wr_err = 1'b0;

    axi4lite_cpuif_bridge #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(64)
    ) dut (
        .clk(clk), .rst(rst),
        .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready), .s_axil_awaddr(s_axil_awaddr),
        .s_axil_wvalid(s_axil_wvalid), .s_axil_wready(s_axil_wready), .s_axil_wdata(s_axil_wdata),
        .s_axil_wstrb(s_axil_wstrb),
        .s_axil_bvalid(s_axil_bvalid), .s_axil_bready(s_axil_bready), .s_axil_bresp(s_axil_bresp),
        .s_axil_arvalid(s_axil_arvalid), .s_axil_arready(s_axil_arready), .s_axil_araddr(s_axil_araddr),
        .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready), .s_axil_rdata(s_axil_rdata),
        .s_axil_rresp(s_axil_rresp),
        .cpuif_req(cpuif_req), .cpuif_req_is_wr(cpuif_req_is_wr), .cpuif_addr(cpuif_addr),
        .cpuif_wr_data(cpuif_wr_data), .cpuif_wr_bitstrb(cpuif_wr_bitstrb),
        .cpuif_rd_ack(cpuif_rd_ack), .cpuif_rd_err(cpuif_rd_err), .cpuif_rd_data(cpuif_rd_data),
        .cpuif_wr_ack(cpuif_wr_ack), .cpuif_wr_err(cpuif_wr_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          is_wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] bstrb;
    } req_t;

    typedef struct {
        bit          is_wr;
        logic [1:0]  resp;
        logic [31:0] rdata;
        int          lat;      // cycles from req to handshake, -1 = unchecked
    } rsp_t;

    req_t exp_req[$];
    rsp_t exp_rsp[$];

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input bit ok, input string act, input string exp);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %s, expected %s", name, act, exp);
    endtask

    // cpuif responder settings
    bit          rsp_suppress = 1'b0;
    int          ack_delay    = 0;
    bit          ack_err      = 1'b0;
    logic [31:0] ack_rdata    = '0;
    bit          rsp_w;

    initial begin
        forever begin
            @(negedge clk);
            if (cpuif_req && !rsp_suppress && !rst) begin
                rsp_w = cpuif_req_is_wr;
                repeat (ack_delay) @(negedge clk);
                if (!rsp_suppress && !rst) begin
                    if (rsp_w) begin
                        cpuif_wr_ack = 1'b1;
                        cpuif_wr_err = ack_err;
                    end else begin
                        cpuif_rd_ack  = 1'b1;
                        cpuif_rd_err  = ack_err;
                        cpuif_rd_data = ack_rdata;
                    end
                    @(negedge clk);
                    cpuif_wr_ack = 1'b0; cpuif_wr_err = 1'b0;
                    cpuif_rd_ack = 1'b0; cpuif_rd_err = 1'b0; cpuif_rd_data = '0;
                end
            end
        end
    end

    // Monitor: compares each request pulse and each B/R handshake with the scoreboard.
    int   last_req_cyc = 0;
    req_t mq;
    rsp_t mr;

    always @(negedge clk) begin
        if (!rst) begin
            if (cpuif_req) begin
                last_req_cyc = cyc;
                if (exp_req.size() == 0) begin
                    chk("req_unexpected", 1'b0, $sformatf("addr=%h wr=%0d", cpuif_addr, cpuif_req_is_wr), "no request");
                end else begin
                    mq = exp_req.pop_front();
                    chk("req", cpuif_req_is_wr == mq.is_wr && cpuif_addr == mq.addr &&
                               cpuif_wr_data == mq.data && cpuif_wr_bitstrb == mq.bstrb,
                        $sformatf("wr=%0d addr=%h data=%h bstrb=%h", cpuif_req_is_wr, cpuif_addr, cpuif_wr_data, cpuif_wr_bitstrb),
                        $sformatf("wr=%0d addr=%h data=%h bstrb=%h", mq.is_wr, mq.addr, mq.data, mq.bstrb));
                end
            end
            if (s_axil_bvalid && s_axil_bready) begin
                if (exp_rsp.size() == 0) begin
                    chk("b_unexpected", 1'b0, $sformatf("bresp=%0d", s_axil_bresp), "no response");
                end else begin
                    mr = exp_rsp.pop_front();
                    chk("bresp", mr.is_wr && s_axil_bresp == mr.resp && (mr.lat < 0 || cyc - last_req_cyc == mr.lat),
                        $sformatf("B bresp=%0d lat=%0d", s_axil_bresp, cyc - last_req_cyc),
                        $sformatf("%s resp=%0d lat=%0d", mr.is_wr ? "B" : "R", mr.resp, mr.lat));
                end
            end
            if (s_axil_rvalid && s_axil_rready) begin
                if (exp_rsp.size() == 0) begin
                    chk("r_unexpected", 1'b0, $sformatf("rresp=%0d rdata=%h", s_axil_rresp, s_axil_rdata), "no response");
                end else begin
                    mr = exp_rsp.pop_front();
                    chk("rresp", !mr.is_wr && s_axil_rresp == mr.resp && s_axil_rdata == mr.rdata &&
                                 (mr.lat < 0 || cyc - last_req_cyc == mr.lat),
                        $sformatf("R rresp=%0d rdata=%h lat=%0d", s_axil_rresp, s_axil_rdata, cyc - last_req_cyc),
                        $sformatf("%s resp=%0d rdata=%h lat=%0d", mr.is_wr ? "B" : "R", mr.resp, mr.rdata, mr.lat));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_aw(input logic [31:0] a);
        int n = 0;
        bit ok = 1'b0;
        s_axil_awvalid = 1'b1; s_axil_awaddr = a;
        do begin @(negedge clk); ok = s_axil_awready; step(); n++; end while (!ok && n < 200);
        s_axil_awvalid = 1'b0;
        chk("aw_accept", ok, $sformatf("%0d", ok), "1");
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        bit ok = 1'b0;
        s_axil_wvalid = 1'b1; s_axil_wdata = d; s_axil_wstrb = s;
        do begin @(negedge clk); ok = s_axil_wready; step(); n++; end while (!ok && n < 200);
        s_axil_wvalid = 1'b0;
        chk("w_accept", ok, $sformatf("%0d", ok), "1");
    endtask

    task automatic send_ar(input logic [31:0] a);
        int n = 0;
        bit ok = 1'b0;
        s_axil_arvalid = 1'b1; s_axil_araddr = a;
        do begin @(negedge clk); ok = s_axil_arready; step(); n++; end while (!ok && n < 200);
        s_axil_arvalid = 1'b0;
        chk("ar_accept", ok, $sformatf("%0d", ok), "1");
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_req.size() != 0 || exp_rsp.size() != 0) && n < 400) begin step(); n++; end
        chk(name, exp_req.size() == 0 && exp_rsp.size() == 0,
            $sformatf("pending req=%0d rsp=%0d", exp_req.size(), exp_rsp.size()), "pending 0/0");
    endtask

    task automatic push_wr(input logic [31:0] a, input logic [31:0] d, input logic [31:0] bs,
                           input logic [1:0] resp, input int lat);
        exp_req.push_back('{1'b1, a, d, bs});
        exp_rsp.push_back('{1'b1, resp, 32'h0, lat});
    endtask

    task automatic push_rd(input logic [31:0] a, input logic [1:0] resp, input logic [31:0] rd, input int lat);
        exp_req.push_back('{1'b0, a, 32'h0, 32'h0});
        exp_rsp.push_back('{1'b0, resp, rd, lat});
    endtask

    function automatic bit outs_zero();
        return {s_axil_awready, s_axil_wready, s_axil_arready, s_axil_bvalid, s_axil_rvalid,
                s_axil_bresp, s_axil_rresp, s_axil_rdata, cpuif_req, cpuif_req_is_wr,
                cpuif_addr, cpuif_wr_data, cpuif_wr_bitstrb} == '0;
    endfunction

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", outs_zero(), $sformatf("req=%0d awready=%0d", cpuif_req, s_axil_awready), "all zero");
        rst = 1'b0;
        repeat (2) step();

        // Write with ack in the request cycle; bvalid one cycle after req.
        ack_delay = 0; ack_err = 1'b0;
        push_wr(32'h104, 32'hDEADBEEF, 32'hFFFFFFFF, 2'b00, 1);
        fork
            send_aw(32'h104);
            send_w(32'hDEADBEEF, 4'hF);
        join
        drain("drain_t1");

        // W arrives well before AW.
        send_w(32'h12345678, 4'h5);
        repeat (5) step();
        push_wr(32'h200, 32'h12345678, 32'h00FF00FF, 2'b00, -1);
        send_aw(32'h200);
        drain("drain_t2");

        // Read, late ack with error, response held while rready low.
        ack_delay = 3; ack_err = 1'b1; ack_rdata = 32'h30;
        s_axil_rready = 1'b0;
        push_rd(32'h100, 2'b10, 32'h30, -1);
        send_ar(32'h103);
        n = 0;
        do begin @(negedge clk); n++; end while (!s_axil_rvalid && n < 50);
        for (int i = 0; i < 4; i++) begin
            chk("r_hold", s_axil_rvalid && s_axil_rdata == 32'h30 && s_axil_rresp == 2'b10,
                $sformatf("rvalid=%0d rdata=%h rresp=%0d", s_axil_rvalid, s_axil_rdata, s_axil_rresp),
                "rvalid=1 rdata=00000030 rresp=2");
            @(negedge clk);
        end
        @(posedge clk); #1;
        s_axil_rready = 1'b1;
        drain("drain_t3");

        // Both eligible after a write: read goes first.
        ack_delay = 1; ack_err = 1'b0; ack_rdata = 32'h55;
        push_wr(32'h10, 32'h1, 32'h000000FF, 2'b00, -1);
        fork send_aw(32'h10); send_w(32'h1, 4'h1); join
        drain("drain_t4a_pre");
        push_rd(32'h40, 2'b00, 32'h55, -1);
        push_wr(32'h44, 32'hA5A5A5A5, 32'hFFFF0000, 2'b00, -1);
        fork send_aw(32'h44); send_w(32'hA5A5A5A5, 4'hC); send_ar(32'h40); join
        drain("drain_t4a");

        // Both eligible after a read: write goes first.
        push_rd(32'h20, 2'b00, 32'h55, -1);
        send_ar(32'h20);
        drain("drain_t4b_pre");
        push_wr(32'h48, 32'h0F0F0F0F, 32'hFF00FF00, 2'b00, -1);
        push_rd(32'h4C, 2'b00, 32'h55, -1);
        fork send_aw(32'h48); send_w(32'h0F0F0F0F, 4'hA); send_ar(32'h4E); join
        drain("drain_t4b");

        // Reset during WAIT_ACK drops the transaction.
        rsp_suppress = 1'b1;
        push_wr(32'h300, 32'hCAFEF00D, 32'hFFFFFFFF, 2'b00, -1);
        fork send_aw(32'h300); send_w(32'hCAFEF00D, 4'hF); join
        n = 0;
        while (exp_req.size() != 0 && n < 50) begin step(); n++; end
        repeat (2) step();
        #2 rst = 1'b1;
        #1;
        chk("async_reset_outputs", outs_zero(),
            $sformatf("req=%0d addr=%h bitstrb=%h", cpuif_req, cpuif_addr, cpuif_wr_bitstrb), "all zero");
        exp_rsp.delete();
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        rsp_suppress = 1'b0;
        repeat (5) step();
        ack_delay = 0;
        push_wr(32'h304, 32'h11223344, 32'hFFFFFFFF, 2'b00, 1);
        fork send_aw(32'h304); send_w(32'h11223344, 4'hF); join
        drain("drain_t5");

`ifdef AXI4LITE_CPUIF_BRIDGE_TIMEOUT_EN
        // No ack: forced SLVERR with zero data after the timeout; stray ack ignored.
        rsp_suppress = 1'b1;
        push_rd(32'h80, 2'b10, 32'h0, 64);
        send_ar(32'h80);
        drain("drain_t6");
        cpuif_rd_ack = 1'b1; cpuif_rd_data = 32'hAA;
        step();
        cpuif_rd_ack = 1'b0; cpuif_rd_data = '0;
        repeat (5) step();
        rsp_suppress = 1'b0;
`endif

        repeat (3) step();
        chk("final_queues", exp_req.size() == 0 && exp_rsp.size() == 0,
            $sformatf("pending req=%0d rsp=%0d", exp_req.size(), exp_rsp.size()), "pending 0/0");
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/axi4lite_cpuif_bridge.md
Name: axi4lite_cpuif_bridge

Overview:
- Upstream front-end for the generated register block.
- Terminates an AXI4-Lite slave port and drives the block's internal single-request cpuif bus: req, is_wr, addr, wr_data, wr_bitstrb, with rd/wr ack and err returned.
- Allows one outstanding cpuif transaction; buffers AW/W independently; holds B/R responses until the master accepts them.
- Replaces the inline APB front-end when a design uses an AXI4-Lite interconnect.

Parameters:
- ADDR_WIDTH, 32, AXI and cpuif byte-address width.
- DATA_WIDTH, 32, data width; legal values 32 or 64.
- TIMEOUT_CYCLES, 64, cycles to wait for an ack before a forced error. Used only with the optional feature.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- s_axil_awvalid/awready  in/out  1  write-address handshake
- s_axil_awaddr  in  ADDR_WIDTH  write address
- s_axil_wvalid/wready  in/out  1  write-data handshake
- s_axil_wdata  in  DATA_WIDTH  write data
- s_axil_wstrb  in  DATA_WIDTH/8  byte strobes
- s_axil_bvalid/bready  out/in  1  write-response handshake
- s_axil_bresp  out  2  write response
- s_axil_arvalid/arready  in/out  1  read-address handshake
- s_axil_araddr  in  ADDR_WIDTH  read address
- s_axil_rvalid/rready  out/in  1  read-data handshake
- s_axil_rdata  out  DATA_WIDTH  read data
- s_axil_rresp  out  2  read response
- cpuif_req  out  1  one-cycle request pulse
- cpuif_req_is_wr  out  1  1 = write
- cpuif_addr  out  ADDR_WIDTH  word-aligned address
- cpuif_wr_data  out  DATA_WIDTH  write data
- cpuif_wr_bitstrb  out  DATA_WIDTH  per-bit write enable
- cpuif_rd_ack, cpuif_rd_err  in  1  read completion, read error
- cpuif_rd_data  in  DATA_WIDTH  read data
- cpuif_wr_ack, cpuif_wr_err  in  1  write completion, write error

Behaviour:
- Reset: clk domain, asynchronous assert, active-high. All outputs 0; holding registers invalid; FSM = IDLE. A transaction in flight at reset is dropped and no response is issued.
- Holding registers: one-entry each for AW, W and AR.
  - awready = !aw_held; wready = !w_held; arready = !ar_held.
  - A held entry is freed in the cycle its cpuif request issues.
- FSM IDLE:
  - A write is eligible when aw_held && w_held. A read is eligible when ar_held.
  - If both are eligible: the write wins unless the last granted op was a write, in which case the read wins (alternating fairness).
  - On grant: cpuif_req = 1 for exactly one cycle, from a register. addr/data/bitstrb are registered and stable from the req cycle until ack.
  - Next state = WAIT_ACK.
- Address: cpuif_addr = axaddr with the log2(DATA_WIDTH/8) LSBs cleared.
- Bit strobe: cpuif_wr_bitstrb[8*i+7:8*i] = {8{wstrb[i]}}. Read requests drive bitstrb = 0.
- WAIT_ACK:
  - The matching ack (wr_ack for a write, rd_ack for a read) may arrive in the req cycle itself (0-cycle) or any cycle later.
  - On ack: capture err and rdata; next state = RESP.
  - Acks of the wrong type, or acks in IDLE/RESP, are ignored.
- RESP:
  - Assert bvalid or rvalid; resp = SLVERR (2'b10) if err, else OKAY (2'b00).
  - Values hold stable until bready/rready; the handshake cycle returns the FSM to IDLE.
  - A new cpuif_req is issued no earlier than the cycle after the handshake.
- Minimum latency: AW+W in cycle 0 → req in cycle 1 → ack in cycle 1 → bvalid in cycle 2.
- No new request is issued while in WAIT_ACK or RESP.
- Holding registers continue to accept while busy, giving one-deep pipelining of addresses.

Optional Feature:
- Macro: AXI4LITE_CPUIF_BRIDGE_TIMEOUT_EN.
- Defined: a counter runs in WAIT_ACK. When it reaches TIMEOUT_CYCLES with no matching ack, the FSM forces RESP with SLVERR and rdata = 0. A late ack for that transaction is ignored.
- Undefined: the bridge waits indefinitely; the counter logic is absent.

Decomposition:
- Package axi4lite_cpuif_pkg:
  - axi_resp_e (OKAY = 2'b00, SLVERR = 2'b10)
  - bridge_state_e (IDLE, WAIT_ACK, RESP)
  - function strb_to_bitstrb
- Sub-module axi4lite_hold_reg: one-entry valid/ready holding register, instantiated for AW, W and AR.

Test Plan:
- AW 0x104 + W 0xDEADBEEF, wstrb 0xF, same cycle; wr_ack in the req cycle → one req pulse, addr 0x104, bitstrb 0xFFFFFFFF; bvalid 1 cycle later, bresp 0.
- W arrives 5 cycles before AW 0x200, wstrb 0x5 → single req after AW, bitstrb 0x00FF00FF.
- AR 0x103, rd_ack 3 cycles after req with rd_data 0x30, rd_err 1; rready held low 4 cycles → cpuif_addr 0x100; rvalid held with rdata 0x30, rresp 2 until rready.
- Write and read eligible together with last op a write → read granted first, then write. Repeat with last op a read → write first.
- Reset asserted while in WAIT_ACK → outputs 0 immediately (asynchronous); no bvalid after release; the next AW/W completes normally.
- With AXI4LITE_CPUIF_BRIDGE_TIMEOUT_EN, no ack → rresp SLVERR and rdata 0 at req+64 cycles; a stray rd_ack afterwards has no effect.
